ttc3_cmd_initiator: RTL and testbench

TTC3_CMD_INITIATOR -- requirements
Module: ttc3_cmd_initiator

---
 rtl/ttc3_pkg.sv | 29 ++
 rtl/ttc3_cmd_initiator.sv | 155 +++++++++++++++
 tb/tb_ttc3_cmd_initiator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ttc3_pkg.sv
// ttc3_pkg: opcodes, status codes and FSM states shared by the TTC3 command logic
package ttc3_pkg;

    localparam logic [2:0] OP_GET_ID     = 3'b001;
    localparam logic [2:0] OP_SHA256     = 3'b010;
    localparam logic [2:0] OP_HMAC       = 3'b011;
    localparam logic [2:0] OP_AES_CTR    = 3'b100;
    localparam logic [2:0] OP_DERIVE_KEY = 3'b101;

    typedef enum logic [1:0] {
        ST_OK         = 2'b00,
        ST_TIMEOUT    = 2'b01,
        ST_ILLEGAL_OP = 2'b10,
        ST_STRAY      = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ISSUE,
        S_WAIT_RESP,
        S_DELIVER
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op inside {OP_GET_ID, OP_SHA256, OP_HMAC, OP_AES_CTR, OP_DERIVE_KEY};
    endfunction

endpackage

// File: rtl/ttc3_cmd_initiator.sv
// ttc3_cmd_initiator: turns one host request into one TTC3 command and returns a single status-tagged response
module ttc3_cmd_initiator
    import ttc3_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic [2:0]            host_req_op,
    input  logic [DATA_WIDTH-1:0] host_req_data,
    output logic                  host_rsp_valid,
    input  logic                  host_rsp_ready,
    output logic [2:0]            host_rsp_op,
    output logic [1:0]            host_rsp_status,
    output logic [DATA_WIDTH-1:0] host_rsp_data,
    output logic                  cmd_valid,
    output logic [2:0]            cmd_op,
    output logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_ready,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            req_op_q, req_op_d;
    logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
    logic [2:0]            cmd_op_q, cmd_op_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    status_e               status_q, status_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  hit_q, hit_d;
    logic                  stray_q, stray_d;
    logic                  counting, timed_out, stray_evt, accept;

    assign accept    = host_req_valid && host_req_ready;
    assign counting  = state_q inside {S_WAIT_READY, S_ISSUE, S_WAIT_RESP};
    assign timed_out = cnt_q >= CNT_LAST;
    assign stray_evt = resp_valid && state_q != S_WAIT_RESP;

    // Next-state and datapath updates; a captured response (hit_q) always beats the timeout
    always_comb begin
        state_d    = state_q;
        req_op_d   = req_op_q;
        req_data_d = req_data_q;
        cmd_op_d   = cmd_op_q;
        cmd_data_d = cmd_data_q;
        status_d   = status_q;
        rsp_data_d = rsp_data_q;
        hit_d      = 1'b0;
        stray_d    = stray_q;
        cnt_d      = (counting && cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_op_d   = host_req_op;
                    req_data_d = host_req_data;
                    cnt_d      = '0;
                    if (op_is_legal(host_req_op)) begin
                        state_d = S_WAIT_READY;
                    end else begin
                        state_d    = S_DELIVER;
                        status_d   = ST_ILLEGAL_OP;
                        rsp_data_d = '0;
                    end
                end
            end
            S_WAIT_READY: begin
                if (timed_out) begin
                    state_d    = S_DELIVER;
                    status_d   = ST_TIMEOUT;
                    rsp_data_d = '0;
                end else if (cmd_ready) begin
                    state_d    = S_ISSUE;
                    cmd_op_d   = req_op_q;
                    cmd_data_d = req_data_q;
                end
            end
            S_ISSUE: begin
                if (timed_out) begin
                    state_d    = S_DELIVER;
                    status_d   = ST_TIMEOUT;
                    rsp_data_d = '0;
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (hit_q) begin
                    state_d  = S_DELIVER;
                    status_d = stray_q ? ST_STRAY : ST_OK;
                end else if (resp_valid) begin
                    hit_d      = 1'b1;
                    rsp_data_d = resp_data;
                end else if (timed_out) begin
                    state_d    = S_DELIVER;
                    status_d   = ST_TIMEOUT;
                    rsp_data_d = '0;
                end
            end
            S_DELIVER: begin
                if (host_rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DELIVER && state_q != S_DELIVER) stray_d = 1'b0;
        if (stray_evt) stray_d = 1'b1;
    end

    // State and datapath registers, all cleared by reset so an abandoned command leaves nothing behind
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_op_q   <= '0;
            req_data_q <= '0;
            cmd_op_q   <= '0;
            cmd_data_q <= '0;
            status_q   <= ST_OK;
            rsp_data_q <= '0;
            hit_q      <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_op_q   <= req_op_d;
            req_data_q <= req_data_d;
            cmd_op_q   <= cmd_op_d;
            cmd_data_q <= cmd_data_d;
            status_q   <= status_d;
            rsp_data_q <= rsp_data_d;
            hit_q      <= hit_d;
            stray_q    <= stray_d;
        end
    end

    assign host_req_ready  = reset_n && state_q == S_IDLE;
    assign busy            = state_q != S_IDLE;
    assign cmd_valid       = state_q == S_ISSUE;
    assign cmd_op          = cmd_op_q;
    assign cmd_data        = cmd_data_q;
    assign host_rsp_valid  = state_q == S_DELIVER;
    assign host_rsp_op     = req_op_q;
    assign host_rsp_status = status_q;
    assign host_rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_ttc3_cmd_initiator.sv
// tb_ttc3_cmd_initiator: transaction-level model of the initiator driven by directed and random traffic
module tb_ttc3_cmd_initiator;

    localparam int DW = 64;
    localparam int T  = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          host_req_valid = 1'b0;
    logic          host_req_ready;
    logic [2:0]    host_req_op = '0;
    logic [DW-1:0] host_req_data = '0;
    logic          host_rsp_valid;
    logic          host_rsp_ready = 1'b0;
    logic [2:0]    host_rsp_op;
    logic [1:0]    host_rsp_status;
    logic [DW-1:0] host_rsp_data;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready = 1'b0;
    logic          resp_valid = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic          busy;

    int            n_chk = 0;
    int            n_bad = 0;
    bit            stray_pend = 1'b0;
    logic [2:0]    last_op = '0;
    logic [DW-1:0] last_data = '0;

    always #5 clock = ~clock;

    ttc3_cmd_initiator #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_op(host_req_op), .host_req_data(host_req_data),
        .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
        .host_rsp_op(host_rsp_op), .host_rsp_status(host_rsp_status), .host_rsp_data(host_rsp_data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic gap_stray();
        @(negedge clock);
        resp_valid = 1'b1;
        resp_data  = rnd64();
        @(negedge clock);
        resp_valid = 1'b0;
        stray_pend = 1'b1;
    endtask

    // d: cycles cmd_ready stays low; r: cycles after the command pulse until resp_valid; h: host back-pressure cycles
    task automatic run_tx(input logic [2:0] op, input logic [DW-1:0] data, input int d, input int r,
                          input logic [DW-1:0] rdata, input int h, input bit stray1);
        bit            legal;
        int            exp_edge, exp_pulses, first, pulses;
        logic [1:0]    exp_st, st0;
        logic [DW-1:0] exp_data, d0;
        bit            ok;
        legal  = op >= 3'd1 && op <= 3'd5;
        first  = -1;
        pulses = 0;
        if (!legal) begin
            exp_edge = 0; exp_st = 2'b10; exp_data = '0; exp_pulses = 0;
        end else if (d + 2 + r <= T) begin
            exp_edge = d + 3 + r; exp_st = 2'b00; exp_data = rdata; exp_pulses = 1;
        end else begin
            exp_edge = T; exp_st = 2'b01; exp_data = '0; exp_pulses = (d + 2 <= T) ? 1 : 0;
        end
        if (legal && stray1) stray_pend = 1'b1;
        if (exp_st == 2'b00 && stray_pend) exp_st = 2'b11;
        stray_pend = 1'b0;
        if (exp_pulses == 1) begin
            last_op   = op;
            last_data = data;
        end
        @(negedge clock);
        host_req_valid = 1'b1;
        host_req_op    = op;
        host_req_data  = data;
        chk("req_ready", host_req_ready, 1);
        @(posedge clock);
        #1 host_req_valid = 1'b0;
        for (int k = 0; k < 40 && first < 0; k++) begin
            @(negedge clock);
            if (cmd_valid) begin
                pulses++;
                chk("cmd_op", cmd_op, op);
                chk("cmd_data", cmd_data, data);
            end
            if (host_rsp_valid) begin
                first      = k;
                cmd_ready  = 1'b0;
                resp_valid = 1'b0;
            end else begin
                cmd_ready  = legal && k >= d;
                resp_valid = legal && (k + 1 == d + 2 + r || (stray1 && k == 0));
                resp_data  = (k + 1 == d + 2 + r) ? rdata : rnd64();
            end
        end
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        chk("latency", first, exp_edge);
        chk("pulses", pulses, exp_pulses);
        chk("rsp_op", host_rsp_op, op);
        chk("rsp_status", host_rsp_status, exp_st);
        chk("rsp_data", host_rsp_data, exp_data);
        chk("busy_deliver", busy, 1);
        chk("cmd_hold_op", cmd_op, last_op);
        chk("cmd_hold_data", cmd_data, last_data);
        st0 = host_rsp_status;
        d0  = host_rsp_data;
        ok  = 1'b1;
        for (int i = 0; i < h; i++) begin
            @(negedge clock);
            ok &= host_rsp_valid && !host_req_ready && !cmd_valid && host_rsp_op == op
                  && host_rsp_status == st0 && host_rsp_data == d0;
        end
        if (h > 0) chk("hold_stable", ok, 1);
        host_rsp_ready = 1'b1;
        @(negedge clock);
        host_rsp_ready = 1'b0;
        chk("after_hs", {host_rsp_valid, busy, host_req_ready}, 3'b001);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {cmd_valid, host_rsp_valid, busy, host_req_ready, host_rsp_op, host_rsp_status, cmd_op,
                  |host_rsp_data, |cmd_data}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (2) @(negedge clock);
        chk_all_zero("reset_outs");
        reset_n = 1'b1;
        #1 chk("ready_after_rst", host_req_ready, 1);

        run_tx(3'd1, 64'h1234, 0, 1, 64'h1234, 0, 0);
        run_tx(3'd7, rnd64(), 0, 1, rnd64(), 0, 0);
        run_tx(3'd0, rnd64(), 0, 1, rnd64(), 1, 0);
        run_tx(3'd6, rnd64(), 0, 1, rnd64(), 0, 0);
        run_tx(3'd2, rnd64(), 0, 100, rnd64(), 0, 0);
        run_tx(3'd3, rnd64(), 5, 1, rnd64(), 0, 0);
        run_tx(3'd4, rnd64(), 0, 2, rnd64(), 10, 0);
        run_tx(3'd5, rnd64(), 20, 1, rnd64(), 0, 0);
        run_tx(3'd1, rnd64(), 3, 11, rnd64(), 0, 0);
        run_tx(3'd2, rnd64(), 3, 12, rnd64(), 0, 0);
        run_tx(3'd3, rnd64(), 14, 1, rnd64(), 0, 0);
        run_tx(3'd4, rnd64(), 15, 1, rnd64(), 0, 0);
        run_tx(3'd1, rnd64(), 2, 1, rnd64(), 0, 1);
        gap_stray();
        run_tx(3'd7, rnd64(), 0, 1, rnd64(), 0, 0);
        run_tx(3'd5, rnd64(), 0, 1, rnd64(), 0, 0);
        gap_stray();
        run_tx(3'd2, rnd64(), 1, 3, rnd64(), 2, 0);

        gap_stray();
        @(negedge clock);
        host_req_valid = 1'b1;
        host_req_op    = 3'd2;
        host_req_data  = rnd64();
        chk("rst_req_ready", host_req_ready, 1);
        @(posedge clock);
        #1 host_req_valid = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) @(negedge clock);
        cmd_ready = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("mid_rst_outs");
        resp_valid = 1'b1;
        resp_data  = rnd64();
        @(negedge clock);
        resp_valid = 1'b0;
        chk_all_zero("rst_held_outs");
        reset_n    = 1'b1;
        stray_pend = 1'b0;
        last_op    = '0;
        last_data  = '0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clock);
            ok &= !host_rsp_valid && !busy && host_req_ready && !cmd_valid;
        end
        chk("post_rst_quiet", ok, 1);
        run_tx(3'd1, rnd64(), 0, 1, rnd64(), 0, 0);

        for (int n = 0; n < 40; n++) begin
            int d, r, h;
            bit s;
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 18) : $urandom_range(0, 4);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 16) : $urandom_range(1, 6);
            h = $urandom_range(0, 3);
            s = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 5) == 0) gap_stray();
            run_tx(3'($urandom_range(0, 7)), rnd64(), d, r, rnd64(), h, s);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
